// File: rtl/sc_game_status_pkg.sv
// Shared codes for the game-status responder and the principal game FSM:
// state encodings, NEXTLEVEL/RESETLEVEL command codes and small counter helpers.
package sc_game_status_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOSE = 2'd2,
    ST_WIN  = 2'd3
  } game_state_e;

  localparam logic [3:0] NL_NONE  = 4'd0;
  localparam logic [3:0] NL_HOUSE = 4'd1;
  localparam logic [3:0] NL_LEVEL = 4'd2;
  localparam logic [3:0] NL_WIN   = 4'd3;

  localparam logic [2:0] RL_NONE  = 3'd0;
  localparam logic [2:0] RL_LIFE  = 3'd1;
  localparam logic [2:0] RL_LOSE  = 3'd2;

  // Counters never wrap: decrement stops at zero, increment stops at the ceiling.
  function automatic logic [3:0] sat_dec(input logic [3:0] value);
    return (value == 4'd0) ? 4'd0 : value - 4'd1;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] ceiling);
    return (value >= ceiling) ? ceiling : value + 4'd1;
  endfunction

endpackage

// File: rtl/sc_edge_rise.sv
// 1-bit registered rising-edge detector; rise is high while din=1 and the
// value seen at the previous clock edge was 0.
module sc_edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb begin
    prev_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/sc_game_status.sv
// Game-status responder: owns HOUSES/LIVECOUNT/LEVELCOUNT, arbitrates the
// FSM's commands by priority and produces the frog-reset pulse and end flags.
module sc_game_status #(
  parameter logic [3:0] INIT_LIVES   = 4'd3,
  parameter logic [3:0] MAX_LEVEL    = 4'd3,
  parameter int         GUARD_CYCLES = 50000000,
  parameter int         GUARD_W      = 26
) (
  input  logic       SC_GAMESTATUS_CLOCK_50,
  input  logic       SC_GAMESTATUS_RESET_InLow,
  input  logic [3:0] SC_GAMESTATUS_NEXTLEVEL,
  input  logic [2:0] SC_GAMESTATUS_RESETLEVEL,
  input  logic       SC_GAMESTATUS_LIVEOUT,
  input  logic       SC_GAMESTATUS_LEVELOUT,
  input  logic [7:0] SC_GAMESTATUS_LEVELOR,
  input  logic       SC_GAMESTATUS_START,
  output logic [7:0] SC_GAMESTATUS_HOUSES,
  output logic [3:0] SC_GAMESTATUS_LIVECOUNT,
  output logic [3:0] SC_GAMESTATUS_LEVELCOUNT,
  output logic       SC_GAMESTATUS_FROGRESET,
  output logic       SC_GAMESTATUS_GAMEOVER,
  output logic       SC_GAMESTATUS_WIN
);

  import sc_game_status_pkg::*;

  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  logic clk;
  logic rst_n;
  assign clk   = SC_GAMESTATUS_CLOCK_50;
  assign rst_n = SC_GAMESTATUS_RESET_InLow;

  logic live_rise;
  logic level_rise;

  sc_edge_rise u_live_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SC_GAMESTATUS_LIVEOUT),
    .rise  (live_rise)
  );

  sc_edge_rise u_level_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (SC_GAMESTATUS_LEVELOUT),
    .rise  (level_rise)
  );

  game_state_e        state_d,    state_q;
  logic [7:0]         houses_d,   houses_q;
  logic [3:0]         lives_d,    lives_q;
  logic [3:0]         level_d,    level_q;
  logic [GUARD_W-1:0] guard_d,    guard_q;
  logic               frog_d,     frog_q;
  logic               gameover_d, gameover_q;
  logic               win_d,      win_q;
  logic               retrigger;

  // Only the highest-priority event of a cycle acts; anything below it is dropped.
  always_comb begin
    state_d   = state_q;
    houses_d  = houses_q;
    lives_d   = lives_q;
    level_d   = level_q;
    guard_d   = guard_q;
    frog_d    = 1'b0;
    retrigger = 1'b0;

    case (state_q)
      ST_LOSE, ST_WIN: begin
        if (SC_GAMESTATUS_START) begin
          state_d  = ST_PLAY;
          houses_d = 8'h00;
          lives_d  = INIT_LIVES;
          level_d  = 4'd0;
          guard_d  = '0;
        end
      end
      default: begin
        if (SC_GAMESTATUS_RESETLEVEL == RL_LOSE) begin
          state_d = ST_LOSE;
        end else if (SC_GAMESTATUS_NEXTLEVEL == NL_WIN) begin
          state_d = ST_WIN;
        end else if (live_rise && (state_q == ST_PLAY)) begin
          // A loss with no lives left is still taken, it just changes nothing.
          if (lives_q != 4'd0) begin
            lives_d   = sat_dec(lives_q);
            retrigger = 1'b1;
          end
        end else if (level_rise) begin
          level_d   = sat_inc(level_q, MAX_LEVEL);
          houses_d  = 8'h00;
          retrigger = 1'b1;
        end else if ((SC_GAMESTATUS_NEXTLEVEL == NL_HOUSE) &&
                     ((SC_GAMESTATUS_LEVELOR & ~houses_q) != 8'h00)) begin
          houses_d  = SC_GAMESTATUS_LEVELOR;
          retrigger = 1'b1;
        end

        if (retrigger) begin
          frog_d  = 1'b1;
          state_d = ST_HOLD;
          guard_d = '0;
        end else if ((state_q == ST_HOLD) && (state_d == ST_HOLD)) begin
          if (guard_q == GUARD_LAST) begin
            state_d = ST_PLAY;
            guard_d = '0;
          end else begin
            guard_d = guard_q + 1'b1;
          end
        end
      end
    endcase

    gameover_d = (state_d == ST_LOSE);
    win_d      = (state_d == ST_WIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PLAY;
      houses_q   <= 8'h00;
      lives_q    <= INIT_LIVES;
      level_q    <= 4'd0;
      guard_q    <= '0;
      frog_q     <= 1'b0;
      gameover_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      houses_q   <= houses_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      guard_q    <= guard_d;
      frog_q     <= frog_d;
      gameover_q <= gameover_d;
      win_q      <= win_d;
    end
  end

  assign SC_GAMESTATUS_HOUSES     = houses_q;
  assign SC_GAMESTATUS_LIVECOUNT  = lives_q;
  assign SC_GAMESTATUS_LEVELCOUNT = level_q;
  assign SC_GAMESTATUS_FROGRESET  = frog_q;
  assign SC_GAMESTATUS_GAMEOVER   = gameover_q;
  assign SC_GAMESTATUS_WIN        = win_q;

endmodule

// File: tb/tb_sc_game_status.sv
// Self-checking bench for sc_game_status: directed scenarios plus randomized
// traffic compared against a behavioural model of the game rules.
module tb_sc_game_status;

  localparam int GUARD  = 8;
  localparam int M_PLAY = 0;
  localparam int M_HOLD = 1;
  localparam int M_LOSE = 2;
  localparam int M_WIN  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] nextlevel = 4'd0;
  logic [2:0] resetlevel = 3'd0;
  logic       liveout = 1'b0;
  logic       levelout = 1'b0;
  logic [7:0] levelor = 8'h00;
  logic       start = 1'b0;

  logic [7:0] houses;
  logic [3:0] livecount;
  logic [3:0] levelcount;
  logic       frogreset;
  logic       gameover;
  logic       win;

  int checks = 0;
  int errors = 0;
  int obs_frog = 0;

  int         m_mode;
  logic [7:0] m_houses;
  int         m_lives;
  int         m_level;
  int         m_hold_left;
  bit         m_frog;
  bit         m_prev_live;
  bit         m_prev_level;

  always #5 clk = ~clk;

  sc_game_status #(
    .INIT_LIVES   (4'd3),
    .MAX_LEVEL    (4'd3),
    .GUARD_CYCLES (GUARD),
    .GUARD_W      (26)
  ) dut (
    .SC_GAMESTATUS_CLOCK_50    (clk),
    .SC_GAMESTATUS_RESET_InLow (rst_n),
    .SC_GAMESTATUS_NEXTLEVEL   (nextlevel),
    .SC_GAMESTATUS_RESETLEVEL  (resetlevel),
    .SC_GAMESTATUS_LIVEOUT     (liveout),
    .SC_GAMESTATUS_LEVELOUT    (levelout),
    .SC_GAMESTATUS_LEVELOR     (levelor),
    .SC_GAMESTATUS_START       (start),
    .SC_GAMESTATUS_HOUSES      (houses),
    .SC_GAMESTATUS_LIVECOUNT   (livecount),
    .SC_GAMESTATUS_LEVELCOUNT  (levelcount),
    .SC_GAMESTATUS_FROGRESET   (frogreset),
    .SC_GAMESTATUS_GAMEOVER    (gameover),
    .SC_GAMESTATUS_WIN         (win)
  );

  function automatic void model_reset();
    m_mode       = M_PLAY;
    m_houses     = 8'h00;
    m_lives      = 3;
    m_level      = 0;
    m_hold_left  = 0;
    m_frog       = 1'b0;
    m_prev_live  = 1'b0;
    m_prev_level = 1'b0;
  endfunction

  // One clock of the game rules, applied to the inputs present before the edge.
  function automatic void model_step();
    bit live_rise  = liveout && !m_prev_live;
    bit level_rise = levelout && !m_prev_level;
    bit restart_hold = 1'b0;
    m_frog = 1'b0;
    if (m_mode == M_LOSE || m_mode == M_WIN) begin
      if (start) begin
        m_mode   = M_PLAY;
        m_houses = 8'h00;
        m_lives  = 3;
        m_level  = 0;
      end
    end else begin
      if (resetlevel == 3'd2) begin
        m_mode = M_LOSE;
      end else if (nextlevel == 4'd3) begin
        m_mode = M_WIN;
      end else if (live_rise && m_mode == M_PLAY) begin
        if (m_lives > 0) begin
          m_lives      = m_lives - 1;
          restart_hold = 1'b1;
        end
      end else if (level_rise) begin
        if (m_level < 3) m_level = m_level + 1;
        m_houses     = 8'h00;
        restart_hold = 1'b1;
      end else if (nextlevel == 4'd1 && (levelor & ~m_houses) != 8'h00) begin
        m_houses     = levelor;
        restart_hold = 1'b1;
      end
      if (restart_hold) begin
        m_frog      = 1'b1;
        m_mode      = M_HOLD;
        m_hold_left = GUARD;
      end else if (m_mode == M_HOLD) begin
        m_hold_left = m_hold_left - 1;
        if (m_hold_left == 0) m_mode = M_PLAY;
      end
    end
    m_prev_live  = liveout;
    m_prev_level = levelout;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (frogreset === 1'b1) obs_frog++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    nextlevel  = 4'd0;
    resetlevel = 3'd0;
    liveout    = 1'b0;
    levelout   = 1'b0;
    levelor    = 8'h00;
    start      = 1'b0;
    model_reset();
    #20;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    obs_frog = 0;
    checks++;
    if (livecount !== 4'd3) begin errors++; $display("[TB] FAIL reset_lives: got %0d expected 3", livecount); end
    idle(20);
    checks++;
    if (houses !== 8'h00) begin errors++; $display("[TB] FAIL reset_houses: got %h expected 00", houses); end
    checks++;
    if (livecount !== 4'd3) begin errors++; $display("[TB] FAIL idle_lives: got %0d expected 3", livecount); end
    checks++;
    if (levelcount !== 4'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", levelcount); end
    checks++;
    if (obs_frog !== 0) begin errors++; $display("[TB] FAIL reset_frog: got %0d pulses expected 0", obs_frog); end
    checks++;
    if (gameover !== 1'b0 || win !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got go=%b win=%b expected 0 0", gameover, win); end
  endtask

  task automatic test_house_capture();
    obs_frog  = 0;
    nextlevel = 4'd1;
    levelor   = 8'h03;
    idle(3);
    nextlevel = 4'd0;
    idle(2);
    checks++;
    if (houses !== 8'h03) begin errors++; $display("[TB] FAIL capture_houses: got %h expected 03", houses); end
    checks++;
    if (obs_frog !== 1) begin errors++; $display("[TB] FAIL capture_pulse: got %0d pulses expected 1", obs_frog); end
    idle(GUARD + 2);
    obs_frog  = 0;
    nextlevel = 4'd1;
    idle(2);
    nextlevel = 4'd0;
    tick();
    checks++;
    if (obs_frog !== 0) begin errors++; $display("[TB] FAIL capture_repeat_pulse: got %0d pulses expected 0", obs_frog); end
    checks++;
    if (houses !== 8'h03) begin errors++; $display("[TB] FAIL capture_repeat_houses: got %h expected 03", houses); end
  endtask

  task automatic test_life_loss();
    obs_frog = 0;
    liveout  = 1'b1;
    idle(5);
    liveout  = 1'b0;
    tick();
    liveout  = 1'b1;
    tick();
    liveout  = 1'b0;
    idle(2);
    checks++;
    if (livecount !== 4'd2) begin errors++; $display("[TB] FAIL life_hold_ignore: got %0d expected 2", livecount); end
    checks++;
    if (obs_frog !== 1) begin errors++; $display("[TB] FAIL life_pulse: got %0d pulses expected 1", obs_frog); end
    idle(GUARD + 2);
    liveout = 1'b1;
    tick();
    liveout = 1'b0;
    tick();
    checks++;
    if (livecount !== 4'd1) begin errors++; $display("[TB] FAIL life_second: got %0d expected 1", livecount); end
    idle(GUARD + 2);
    liveout = 1'b1;
    tick();
    liveout = 1'b0;
    idle(GUARD + 2);
    obs_frog = 0;
    liveout  = 1'b1;
    tick();
    liveout  = 1'b0;
    idle(2);
    checks++;
    if (livecount !== 4'd0) begin errors++; $display("[TB] FAIL life_saturate: got %0d expected 0", livecount); end
    checks++;
    if (obs_frog !== 0) begin errors++; $display("[TB] FAIL life_saturate_pulse: got %0d pulses expected 0", obs_frog); end
  endtask

  task automatic test_level();
    idle(GUARD + 2);
    for (int i = 0; i < 2; i++) begin
      levelout = 1'b1;
      tick();
      levelout = 1'b0;
      tick();
    end
    nextlevel = 4'd1;
    levelor   = 8'hFF;
    tick();
    nextlevel = 4'd0;
    tick();
    checks++;
    if (levelcount !== 4'd2 || houses !== 8'hFF) begin errors++; $display("[TB] FAIL level_setup: got lvl=%0d houses=%h expected 2 ff", levelcount, houses); end
    obs_frog = 0;
    levelout = 1'b1;
    tick();
    levelout = 1'b0;
    tick();
    checks++;
    if (levelcount !== 4'd3) begin errors++; $display("[TB] FAIL level_inc: got %0d expected 3", levelcount); end
    checks++;
    if (houses !== 8'h00) begin errors++; $display("[TB] FAIL level_clear_houses: got %h expected 00", houses); end
    checks++;
    if (obs_frog !== 1) begin errors++; $display("[TB] FAIL level_pulse: got %0d pulses expected 1", obs_frog); end
    levelout = 1'b1;
    tick();
    levelout = 1'b0;
    tick();
    checks++;
    if (levelcount !== 4'd3) begin errors++; $display("[TB] FAIL level_saturate: got %0d expected 3", levelcount); end
    checks++;
    if (obs_frog !== 2) begin errors++; $display("[TB] FAIL level_saturate_pulse: got %0d pulses expected 2", obs_frog); end
  endtask

  task automatic test_lose();
    do_reset();
    nextlevel = 4'd1;
    levelor   = 8'h10;
    tick();
    nextlevel = 4'd0;
    idle(GUARD + 2);
    obs_frog   = 0;
    resetlevel = 3'd2;
    liveout    = 1'b1;
    nextlevel  = 4'd1;
    levelor    = 8'h30;
    tick();
    checks++;
    if (gameover !== 1'b1) begin errors++; $display("[TB] FAIL lose_flag: got %b expected 1", gameover); end
    resetlevel = 3'd0;
    liveout    = 1'b0;
    nextlevel  = 4'd3;
    levelout   = 1'b1;
    idle(3);
    nextlevel  = 4'd0;
    levelout   = 1'b0;
    tick();
    checks++;
    if (livecount !== 4'd3 || houses !== 8'h10) begin errors++; $display("[TB] FAIL lose_frozen: got lives=%0d houses=%h expected 3 10", livecount, houses); end
    checks++;
    if (obs_frog !== 0 || win !== 1'b0 || gameover !== 1'b1) begin errors++; $display("[TB] FAIL lose_ignore: got pulses=%0d win=%b go=%b expected 0 0 1", obs_frog, win, gameover); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (gameover !== 1'b0 || houses !== 8'h00 || livecount !== 4'd3 || levelcount !== 4'd0) begin
      errors++;
      $display("[TB] FAIL lose_restart: got go=%b houses=%h lives=%0d lvl=%0d expected 0 00 3 0", gameover, houses, livecount, levelcount);
    end
    liveout = 1'b1;
    tick();
    liveout = 1'b0;
    tick();
    checks++;
    if (livecount !== 4'd2) begin errors++; $display("[TB] FAIL restart_play: got %0d expected 2", livecount); end
  endtask

  task automatic test_win_reset();
    idle(GUARD + 2);
    nextlevel = 4'd1;
    levelor   = 8'h01;
    tick();
    nextlevel = 4'd3;
    tick();
    nextlevel = 4'd0;
    checks++;
    if (win !== 1'b1) begin errors++; $display("[TB] FAIL win_flag: got %b expected 1", win); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (win !== 1'b0 || houses !== 8'h00 || livecount !== 4'd3 || levelcount !== 4'd0 || gameover !== 1'b0) begin
      errors++;
      $display("[TB] FAIL win_async_reset: got win=%b houses=%h lives=%0d lvl=%0d expected 0 00 3 0", win, houses, livecount, levelcount);
    end
    #8;
    do_reset();
    #1;
    nextlevel = 4'd1;
    levelor   = 8'h02;
    tick();
    nextlevel = 4'd0;
    checks++;
    if (frogreset !== 1'b1) begin errors++; $display("[TB] FAIL pulse_before_reset: got %b expected 1", frogreset); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (frogreset !== 1'b0 || houses !== 8'h00) begin errors++; $display("[TB] FAIL pulse_async_reset: got frog=%b houses=%h expected 0 00", frogreset, houses); end
    #8;
    do_reset();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      r = $urandom_range(0, 99);
      resetlevel = (r < 2) ? 3'd2 : 3'($urandom_range(0, 1));
      r = $urandom_range(0, 99);
      if (r < 2)       nextlevel = 4'd3;
      else if (r < 45) nextlevel = 4'd1;
      else if (r < 52) nextlevel = 4'($urandom_range(0, 15));
      else             nextlevel = 4'd0;
      if (nextlevel == 4'd3 && $urandom_range(0, 3) != 0) nextlevel = 4'd2;
      if ($urandom_range(0, 4) == 0) levelor = 8'($urandom);
      else                           levelor = m_houses | (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) liveout  = ~liveout;
      if ($urandom_range(0, 6) == 0) levelout = ~levelout;
      start = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (houses !== m_houses) begin errors++; $display("[TB] FAIL rand_houses cyc %0d: got %h expected %h", cyc, houses, m_houses); end
      checks++;
      if (livecount !== 4'(m_lives)) begin errors++; $display("[TB] FAIL rand_lives cyc %0d: got %0d expected %0d", cyc, livecount, m_lives); end
      checks++;
      if (levelcount !== 4'(m_level)) begin errors++; $display("[TB] FAIL rand_level cyc %0d: got %0d expected %0d", cyc, levelcount, m_level); end
      checks++;
      if (frogreset !== m_frog) begin errors++; $display("[TB] FAIL rand_frog cyc %0d: got %b expected %b", cyc, frogreset, m_frog); end
      checks++;
      if (gameover !== (m_mode == M_LOSE)) begin errors++; $display("[TB] FAIL rand_gameover cyc %0d: got %b expected %b", cyc, gameover, m_mode == M_LOSE); end
      checks++;
      if (win !== (m_mode == M_WIN)) begin errors++; $display("[TB] FAIL rand_win cyc %0d: got %b expected %b", cyc, win, m_mode == M_WIN); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_house_capture();
    test_life_loss();
    test_level();
    test_lose();
    test_win_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_game_status.md
Name: sc_game_status

Overview:
- Responder end of the principal game state machine's command interface: it consumes NEXTLEVEL/RESETLEVEL/LIVEOUT/LEVELOUT/LEVELOR and owns the game-status registers the FSM reads back (HOUSES, LIVECOUNT, LEVELCOUNT).
- It also generates the frog-reset pulse and the game-over and win flags for the display/frog blocks.
- Sits between the principal FSM and the frog/board logic in the top level.

Parameters:
- INIT_LIVES, 3: lives loaded at reset and on restart; 4-bit value.
- MAX_LEVEL, 3: highest LEVELCOUNT value; increments saturate here.
- GUARD_CYCLES, 50000000: hold-off after any frog reset, during which further life-loss requests are ignored. The bench overrides it to 8.
- GUARD_W, 26: width of the guard counter; must hold GUARD_CYCLES.

Ports:
- SC_GAMESTATUS_CLOCK_50  in  1  system clock, 50 MHz.
- SC_GAMESTATUS_RESET_InLow  in  1  asynchronous reset, active-low.
- SC_GAMESTATUS_NEXTLEVEL  in  4  command code: 0 none, 1 house capture, 2 level cleared, 3 win.
- SC_GAMESTATUS_RESETLEVEL  in  3  command code: 0 none, 1 life lost, 2 game lost.
- SC_GAMESTATUS_LIVEOUT  in  1  life-loss request; level signal, may stay high for several cycles.
- SC_GAMESTATUS_LEVELOUT  in  1  level-advance request; level signal.
- SC_GAMESTATUS_LEVELOR  in  8  proposed houses vector (current HOUSES OR newly reached house).
- SC_GAMESTATUS_START  in  1  restart request from the debounced button; honoured only in LOSE or WIN.
- SC_GAMESTATUS_HOUSES  out  8  occupied-houses register.
- SC_GAMESTATUS_LIVECOUNT  out  4  remaining lives.
- SC_GAMESTATUS_LEVELCOUNT  out  4  current level, 0..MAX_LEVEL.
- SC_GAMESTATUS_FROGRESET  out  1  one-cycle pulse that returns the frog to start.
- SC_GAMESTATUS_GAMEOVER  out  1  high while in LOSE.
- SC_GAMESTATUS_WIN  out  1  high while in WIN.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-low.
- Reset values: HOUSES=0x00, LIVECOUNT=INIT_LIVES, LEVELCOUNT=0, FROGRESET=0, GAMEOVER=0, WIN=0, state=PLAY, guard counter=0. Edge-detect flops reset to 0.
- Edge detection: the block registers LIVEOUT and LEVELOUT, and acts only on the rising edge (current=1, previous=0). A request held high therefore counts once.
- States:
  - PLAY: normal play; all events are evaluated.
  - HOLD: counts GUARD_CYCLES, then returns to PLAY. Life-loss requests are ignored in HOLD. House, level and lose/win commands are still evaluated.
  - LOSE: terminal until START.
  - WIN: terminal until START.
- Priority per cycle in PLAY/HOLD, highest first:
  1. RESETLEVEL==2 -> LOSE; GAMEOVER=1 from the next cycle; no counter changes.
  2. NEXTLEVEL==3 -> WIN; WIN=1 from the next cycle; HOUSES unchanged.
  3. LIVEOUT rising edge, PLAY only:
     - If LIVECOUNT>0: LIVECOUNT-1, FROGRESET pulse, go to HOLD with the counter cleared.
     - If LIVECOUNT==0: no change (saturate).
  4. LEVELOUT rising edge:
     - If LEVELCOUNT<MAX_LEVEL: LEVELCOUNT+1, HOUSES=0x00, FROGRESET pulse, go to HOLD.
     - If LEVELCOUNT==MAX_LEVEL: LEVELCOUNT stays at MAX_LEVEL; the other effects still apply.
  5. NEXTLEVEL==1:
     - If (LEVELOR & ~HOUSES)!=0: HOUSES=LEVELOR, FROGRESET pulse, go to HOLD.
     - Otherwise no action; repeated identical captures are idempotent.
- Lower-priority events in the same cycle are discarded, not deferred. A discarded request that is held high does not re-trigger, because it is edge-detected.
- FROGRESET is exactly one cycle wide, asserted the cycle after the triggering event. A new trigger restarts HOLD with the counter cleared.
- HOLD timing: the counter increments each cycle; at GUARD_CYCLES-1 the next state is PLAY.
- LOSE/WIN:
  - Commands and requests are ignored.
  - START=1 reloads every register to its reset value and returns to PLAY the next cycle.
  - START outside LOSE/WIN is ignored.
- Arithmetic: 4-bit unsigned counters, no wrap; decrement saturates at 0, increment saturates at MAX_LEVEL.
- Asynchronous reset mid-HOLD or mid-pulse clears everything immediately; no pending event survives.

Decomposition:
- Shared package holds:
  - state encodings for PLAY/HOLD/LOSE/WIN;
  - NEXTLEVEL codes NL_NONE/NL_HOUSE/NL_LEVEL/NL_WIN = 0/1/2/3;
  - RESETLEVEL codes RL_NONE/RL_LIFE/RL_LOSE = 0/1/2.
- The principal FSM imports the same codes.
- One sub-module: sc_edge_rise, a 1-bit registered rising-edge detector with asynchronous active-low reset. It is instantiated twice, for LIVEOUT and LEVELOUT.

Test Plan:
- Reset release, idle 20 cycles -> HOUSES=0x00, LIVECOUNT=3, LEVELCOUNT=0, FROGRESET never high.
- NEXTLEVEL=1 with LEVELOR=0x03 for 3 cycles -> HOUSES=0x03, exactly one FROGRESET pulse. Then LEVELOR=0x03 again -> no pulse.
- LIVEOUT held high 5 cycles, then a second rising edge during HOLD (GUARD_CYCLES=8) -> LIVECOUNT 3->2 only.
  - A third edge after HOLD expires -> LIVECOUNT=1.
  - Reaching LIVECOUNT=0 and pulsing LIVEOUT -> stays 0.
- LEVELOUT edge with HOUSES=0xFF, LEVELCOUNT=2 -> LEVELCOUNT=3, HOUSES=0x00, one FROGRESET.
  - A further edge -> LEVELCOUNT stays 3.
- Same cycle RESETLEVEL=2, LIVEOUT rise, NEXTLEVEL=1 -> GAMEOVER=1, LIVECOUNT and HOUSES unchanged.
  - START=1 -> all registers back to reset values, state PLAY.
- NEXTLEVEL=3 -> WIN=1. Assert reset low mid-HOLD from the prior test -> WIN=0 and all outputs at reset values immediately, without waiting for a clock edge.
